mem_port_arbiter: RTL and testbench

Arbitrates a single-port unified instruction/data memory between the pipeline's fetch stage (IF) and its memory stage (ME). Serialises one transaction at a time through a four-state sequencer and returns per-requester acknowledges. Produces stall signals that feed the hazard unit, so PC/IF_ID hold while fetch waits and the ME stage freezes while a load/store waits. Adds a timeout so that a non-responding memory cannot hang the core.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and memory-side signals of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the pipeline/memory side.
interface mem_port_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 32
);
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ack;
    logic [DW-1:0] if_rdata;

    logic          dm_req;
    logic          dm_we;
    logic [2:0]    dm_funct3;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ack;
    logic [DW-1:0] dm_rdata;

    logic          err;
    logic          stall_if;
    logic          stall_dm;

    logic          mem_cs;
    logic          mem_we;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rvalid;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
               mem_rvalid, mem_rdata,
        output if_ack, if_rdata, dm_ack, dm_rdata, err, stall_if, stall_dm,
               mem_cs, mem_we, mem_funct3, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_funct3, dm_addr, dm_wdata,
               mem_rvalid, mem_rdata,
        input  if_ack, if_rdata, dm_ack, dm_rdata, err, stall_if, stall_dm,
               mem_cs, mem_we, mem_funct3, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises IF fetches and ME loads/stores onto one memory port with a WAIT timeout.
// Optional macro ARB_RR_EN: round-robin on contention instead of fixed DM priority.
module mem_port_arbiter #(
    parameter int AW     = 8,
    parameter int DW     = 32,
    parameter int TO_CYC = 15
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;
    localparam logic [7:0] TO_LIM  = 8'(TO_CYC);
    localparam logic       OWN_IF  = 1'b0;
    localparam logic       OWN_DM  = 1'b1;

    logic [1:0]    state_reg;
    logic [7:0]    cnt_reg;
    logic          owner_reg;
    logic          cs_reg;
    logic          we_reg;
    logic [2:0]    funct3_reg;
    logic [AW-1:0] addr_reg;
    logic [DW-1:0] wdata_reg;
    logic          if_ack_reg;
    logic          dm_ack_reg;
    logic          err_reg;
    logic [DW-1:0] if_rdata_reg;
    logic [DW-1:0] dm_rdata_reg;

    logic          grant_dm;
    logic          finish;
    logic [DW-1:0] cap_data;

`ifdef ARB_RR_EN
    logic last_owner_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_owner_reg <= OWN_IF;
        else if (state_reg == S_DONE)
            last_owner_reg <= owner_reg;
    end

    // On contention the requester that did not own the previous transaction wins.
    assign grant_dm = bus.dm_req & (~bus.if_req | (last_owner_reg == OWN_IF));
`else
    assign grant_dm = bus.dm_req;
`endif

    // A response on the last allowed WAIT cycle still beats the timeout.
    assign finish   = (state_reg == S_WAIT) & (bus.mem_rvalid | (cnt_reg == TO_LIM));
    assign cap_data = bus.mem_rvalid ? bus.mem_rdata : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            cnt_reg      <= '0;
            owner_reg    <= OWN_IF;
            cs_reg       <= 1'b0;
            we_reg       <= 1'b0;
            funct3_reg   <= '0;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            if_ack_reg   <= 1'b0;
            dm_ack_reg   <= 1'b0;
            err_reg      <= 1'b0;
            if_rdata_reg <= '0;
            dm_rdata_reg <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (bus.if_req | bus.dm_req) begin
                        cs_reg    <= 1'b1;
                        state_reg <= S_ISSUE;
                        if (grant_dm) begin
                            owner_reg  <= OWN_DM;
                            we_reg     <= bus.dm_we;
                            funct3_reg <= bus.dm_funct3;
                            addr_reg   <= bus.dm_addr;
                            wdata_reg  <= bus.dm_wdata;
                        end else begin
                            owner_reg  <= OWN_IF;
                            we_reg     <= 1'b0;
                            funct3_reg <= 3'b010;
                            addr_reg   <= bus.if_addr;
                            wdata_reg  <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    cs_reg    <= 1'b0;
                    cnt_reg   <= '0;
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    if (finish) begin
                        state_reg  <= S_DONE;
                        err_reg    <= ~bus.mem_rvalid;
                        if_ack_reg <= (owner_reg == OWN_IF);
                        dm_ack_reg <= (owner_reg == OWN_DM);
                        if (owner_reg == OWN_DM)
                            dm_rdata_reg <= cap_data;
                        else
                            if_rdata_reg <= cap_data;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    if_ack_reg <= 1'b0;
                    dm_ack_reg <= 1'b0;
                    err_reg    <= 1'b0;
                    state_reg  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_cs     = cs_reg;
    assign bus.mem_we     = we_reg;
    assign bus.mem_funct3 = funct3_reg;
    assign bus.mem_addr   = addr_reg;
    assign bus.mem_wdata  = wdata_reg;
    assign bus.if_ack     = if_ack_reg;
    assign bus.dm_ack     = dm_ack_reg;
    assign bus.err        = err_reg;
    assign bus.if_rdata   = if_rdata_reg;
    assign bus.dm_rdata   = dm_rdata_reg;
    assign bus.stall_if   = bus.if_req & ~if_ack_reg;
    assign bus.stall_dm   = bus.dm_req & ~dm_ack_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomised self-checking bench for mem_port_arbiter against a transaction-level model.
// Build with +define+ARB_RR_EN to check the round-robin variant.
module tb_mem_port_arbiter;
    localparam int AW     = 8;
    localparam int DW     = 32;
    localparam int TO_CYC = 15;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();
    mem_port_arbiter #(.AW(AW), .DW(DW), .TO_CYC(TO_CYC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Transaction-level model state: owner 1 = DM, 0 = IF
    logic          last_owner_m;
    logic [DW-1:0] if_rdata_m;
    logic [DW-1:0] dm_rdata_m;

    // Observations of the latest transaction
    int            obs_cs, obs_ack, obs_cs_extra, obs_stall_if, obs_stall_dm;
    logic          obs_if_ack, obs_dm_ack, obs_err, obs_we;
    logic          obs_stall_if_ack, obs_stall_dm_ack;
    logic [2:0]    obs_f3;
    logic [AW-1:0] obs_addr;
    logic [DW-1:0] obs_wdata, obs_if_rdata, obs_dm_rdata;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic model_pick(input logic if_r, input logic dm_r);
`ifdef ARB_RR_EN
        if (if_r && dm_r) return ~last_owner_m;
`endif
        return dm_r;
    endfunction

    function automatic logic model_delivered(input int lat);
        return (lat >= 1) && (lat <= TO_CYC + 1);
    endfunction

    function automatic int model_delay(input int lat);
        return model_delivered(lat) ? lat + 1 : TO_CYC + 2;
    endfunction

    task automatic model_commit(input logic own, input int lat, input logic [DW-1:0] rd);
        logic [DW-1:0] v;
        v = model_delivered(lat) ? rd : '0;
        if (own) dm_rdata_m = v;
        else     if_rdata_m = v;
        last_owner_m = own;
    endtask

    task automatic model_reset();
        last_owner_m = 1'b0;
        if_rdata_m   = '0;
        dm_rdata_m   = '0;
    endtask

    // Plays the memory: answers in WAIT cycle 'lat' (0 = never) and records what it saw.
    task automatic run_txn(input int lat, input logic [DW-1:0] rdata);
        int n;
        bit got;
        #1;
        obs_cs = -1; obs_ack = -1; obs_cs_extra = 0;
        obs_if_ack = 0; obs_dm_ack = 0; obs_err = 0;
        obs_stall_if_ack = 0; obs_stall_dm_ack = 0;
        obs_stall_if = int'(bus.stall_if);
        obs_stall_dm = int'(bus.stall_dm);
        n = 0;
        while (obs_cs < 0 && n < 8) begin
            tick(); n++;
            obs_stall_if += int'(bus.stall_if);
            obs_stall_dm += int'(bus.stall_dm);
            if (bus.mem_cs) begin
                obs_cs = n; obs_we = bus.mem_we; obs_f3 = bus.mem_funct3;
                obs_addr = bus.mem_addr; obs_wdata = bus.mem_wdata;
            end
        end
        bus.mem_rdata = rdata;
        n = 0; got = 0;
        while (!got && n < TO_CYC + 6) begin
            tick(); n++;
            if (bus.if_ack || bus.dm_ack) begin
                got = 1; obs_ack = n;
                obs_if_ack = bus.if_ack; obs_dm_ack = bus.dm_ack; obs_err = bus.err;
                obs_if_rdata = bus.if_rdata; obs_dm_rdata = bus.dm_rdata;
                obs_stall_if_ack = bus.stall_if; obs_stall_dm_ack = bus.stall_dm;
            end else begin
                obs_stall_if += int'(bus.stall_if);
                obs_stall_dm += int'(bus.stall_dm);
                obs_cs_extra += int'(bus.mem_cs);
            end
            bus.mem_rvalid = !got && (n == lat);
        end
        bus.mem_rvalid = 1'b0;
        $display("[TB] txn cs=%0d ack=%0d if_ack=%0b dm_ack=%0b err=%0b we=%0b addr=%h",
                 obs_cs, obs_ack, obs_if_ack, obs_dm_ack, obs_err, obs_we, obs_addr);
    endtask

    task automatic test_reset();
        logic [113:0] outs;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_funct3 = '0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_rvalid = 0; bus.mem_rdata = '0;
        model_reset();
        tick(); tick();
        outs = {bus.if_ack, bus.dm_ack, bus.err, bus.stall_if, bus.stall_dm, bus.mem_cs,
                bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL reset_outputs: got %h want 0", outs); end
        rst = 1'b0;
        tick(); tick();
        tests_run++;
        if (bus.mem_cs !== 1'b0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_idle: cs=%b if_ack=%b dm_ack=%b want 0 0 0", bus.mem_cs, bus.if_ack, bus.dm_ack);
        end
    endtask

    task automatic test_single_fetch();
        bus.if_req = 1; bus.if_addr = 8'h10;
        run_txn(1, 32'h00500093);
        model_commit(1'b0, 1, 32'h00500093);
        tests_run++;
        if (obs_cs + obs_ack !== 3) begin tests_failed++; $display("FAIL fetch_latency: got %0d want 3", obs_cs + obs_ack); end
        tests_run++;
        if ({obs_if_ack, obs_dm_ack, obs_err} !== 3'b100) begin
            tests_failed++; $display("FAIL fetch_ack: got if/dm/err=%b want 100", {obs_if_ack, obs_dm_ack, obs_err});
        end
        tests_run++;
        if (obs_if_rdata !== if_rdata_m) begin tests_failed++; $display("FAIL fetch_data: got %h want %h", obs_if_rdata, if_rdata_m); end
        tests_run++;
        if (obs_stall_if !== 3 || obs_stall_if_ack !== 1'b0) begin
            tests_failed++; $display("FAIL fetch_stall: got %0d cycles, at ack %b want 3, 0", obs_stall_if, obs_stall_if_ack);
        end
        tests_run++;
        if ({obs_we, obs_f3, obs_addr} !== {1'b0, 3'b010, 8'h10} || obs_cs_extra !== 0) begin
            tests_failed++; $display("FAIL fetch_cmd: got we=%b f3=%b addr=%h extra_cs=%0d want 0 010 10 0", obs_we, obs_f3, obs_addr, obs_cs_extra);
        end
        tick(); bus.if_req = 0;
        tests_run++;
        if (bus.if_ack !== 1'b0) begin tests_failed++; $display("FAIL fetch_ack_pulse: got %b want 0", bus.if_ack); end
    endtask

    task automatic test_contention();
        logic own;
        bus.if_req = 1; bus.if_addr = 8'h10;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_funct3 = 3'b010; bus.dm_addr = 8'h20; bus.dm_wdata = 32'hDEADBEEF;
        own = model_pick(1'b1, 1'b1);
        run_txn(1, 32'h0);
        model_commit(own, 1, 32'h0);
        tests_run++;
        if ({obs_dm_ack, obs_if_ack} !== 2'b10 || own !== 1'b1) begin
            tests_failed++; $display("FAIL contention_first: got dm/if ack=%b want 10", {obs_dm_ack, obs_if_ack});
        end
        tests_run++;
        if ({obs_we, obs_addr, obs_wdata} !== {1'b1, 8'h20, 32'hDEADBEEF}) begin
            tests_failed++; $display("FAIL contention_store_cmd: got we=%b addr=%h wdata=%h want 1 20 deadbeef", obs_we, obs_addr, obs_wdata);
        end
        // DM re-requests right away while IF is still waiting
        tick();
        bus.dm_we = 0; bus.dm_addr = 8'h24; bus.dm_funct3 = 3'b100;
        own = model_pick(1'b1, 1'b1);
        run_txn(2, 32'h11223344);
        model_commit(own, 2, 32'h11223344);
        tests_run++;
        if ({obs_dm_ack, obs_if_ack} !== {own, ~own} || obs_err !== 1'b0) begin
            tests_failed++; $display("FAIL contention_repeat: got dm/if ack=%b err=%b want %b 0", {obs_dm_ack, obs_if_ack}, obs_err, {own, ~own});
        end
        tests_run++;
        if (obs_if_rdata !== if_rdata_m || obs_dm_rdata !== dm_rdata_m) begin
            tests_failed++; $display("FAIL contention_data: got if=%h dm=%h want if=%h dm=%h", obs_if_rdata, obs_dm_rdata, if_rdata_m, dm_rdata_m);
        end
        tick();
        if (own) bus.dm_req = 0; else bus.if_req = 0;
        own = model_pick(bus.if_req, bus.dm_req);
        run_txn(1, 32'h55667788);
        model_commit(own, 1, 32'h55667788);
        tests_run++;
        if ({obs_dm_ack, obs_if_ack} !== {own, ~own} || obs_cs !== 1) begin
            tests_failed++; $display("FAIL contention_drain: got dm/if ack=%b cs=%0d want %b 1", {obs_dm_ack, obs_if_ack}, obs_cs, {own, ~own});
        end
        tick();
        bus.if_req = 0; bus.dm_req = 0;
    endtask

    task automatic test_timeout();
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_funct3 = 3'b010; bus.dm_addr = 8'h40;
        run_txn(0, 32'hCAFEF00D);
        model_commit(1'b1, 0, 32'hCAFEF00D);
        tests_run++;
        if (obs_ack !== TO_CYC + 2) begin tests_failed++; $display("FAIL timeout_latency: got %0d want %0d", obs_ack, TO_CYC + 2); end
        tests_run++;
        if ({obs_dm_ack, obs_err} !== 2'b11 || obs_dm_rdata !== 32'h0) begin
            tests_failed++; $display("FAIL timeout_result: got ack=%b err=%b data=%h want 1 1 0", obs_dm_ack, obs_err, obs_dm_rdata);
        end
        tests_run++;
        if (obs_if_rdata !== if_rdata_m || obs_stall_dm_ack !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_hold: got if=%h stall=%b want %h 0", obs_if_rdata, obs_stall_dm_ack, if_rdata_m);
        end
        tick(); bus.dm_req = 0;
        tests_run++;
        if (bus.err !== 1'b0 || bus.dm_ack !== 1'b0) begin
            tests_failed++; $display("FAIL timeout_clear: got err=%b ack=%b want 0 0", bus.err, bus.dm_ack);
        end
    endtask

    task automatic test_boundary();
        for (int lat = TO_CYC; lat <= TO_CYC + 1; lat++) begin
            bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 8'(8'h50 + lat);
            run_txn(lat, 32'hA5A50000 + 32'(lat));
            model_commit(1'b1, lat, 32'hA5A50000 + 32'(lat));
            tests_run++;
            if (obs_ack !== lat + 1 || obs_err !== 1'b0 || obs_dm_rdata !== dm_rdata_m) begin
                tests_failed++;
                $display("FAIL boundary_lat%0d: got ack=%0d err=%b data=%h want %0d 0 %h", lat, obs_ack, obs_err, obs_dm_rdata, lat + 1, dm_rdata_m);
            end
            tick(); bus.dm_req = 0;
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [113:0] outs;
        int bad;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 8'h30;
        tick(); tick(); tick();
        rst = 1'b1; bus.dm_req = 0;
        model_reset();
        #1;
        outs = {bus.if_ack, bus.dm_ack, bus.err, bus.stall_if, bus.stall_dm, bus.mem_cs,
                bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata};
        tests_run++;
        if (outs !== '0) begin tests_failed++; $display("FAIL midreset_async: got %h want 0", outs); end
        tick(); rst = 1'b0;
        bus.mem_rvalid = 1; bus.mem_rdata = 32'hBAD0BAD0;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick(); bus.mem_rvalid = 0;
            outs = {bus.if_ack, bus.dm_ack, bus.err, bus.stall_if, bus.stall_dm, bus.mem_cs,
                    bus.mem_we, bus.mem_funct3, bus.mem_addr, bus.mem_wdata, bus.if_rdata, bus.dm_rdata};
            if (outs !== '0) bad++;
        end
        tests_run++;
        if (bad !== 0) begin tests_failed++; $display("FAIL midreset_late_rvalid: got %0d non-zero cycles want 0", bad); end
        bus.if_req = 1; bus.if_addr = 8'h44;
        run_txn(1, 32'h00A00113);
        model_commit(1'b0, 1, 32'h00A00113);
        tests_run++;
        if (obs_cs !== 1 || obs_ack !== 2 || obs_if_ack !== 1'b1 || obs_if_rdata !== if_rdata_m) begin
            tests_failed++;
            $display("FAIL midreset_recover: got cs=%0d ack=%0d if_ack=%b data=%h want 1 2 1 %h", obs_cs, obs_ack, obs_if_ack, obs_if_rdata, if_rdata_m);
        end
        tick(); bus.if_req = 0;
    endtask

    task automatic test_random();
        int sel, lat;
        logic own, dlv;
        logic [DW-1:0] rd;
        logic [12+DW-1:0] exp_cmd;
        for (int t = 0; t < 24; t++) begin
            sel = $urandom_range(1, 3);
            bus.if_addr = 8'($urandom); bus.dm_we = 1'($urandom); bus.dm_funct3 = 3'($urandom);
            bus.dm_addr = 8'($urandom); bus.dm_wdata = $urandom;
            bus.if_req = sel[0]; bus.dm_req = sel[1];
            while (bus.if_req || bus.dm_req) begin
                own = model_pick(bus.if_req, bus.dm_req);
                lat = ($urandom_range(0, 5) == 0) ? $urandom_range(TO_CYC, TO_CYC + 4) : $urandom_range(1, 4);
                rd  = $urandom;
                dlv = model_delivered(lat);
                exp_cmd = own ? {bus.dm_we, bus.dm_funct3, bus.dm_addr, bus.dm_wdata}
                              : {1'b0, 3'b010, bus.if_addr, 32'h0};
                run_txn(lat, rd);
                model_commit(own, lat, rd);
                tests_run++;
                if (obs_cs !== 1 || obs_ack !== model_delay(lat)) begin
                    tests_failed++; $display("FAIL random_timing[%0d]: got cs=%0d ack=%0d want 1 %0d", t, obs_cs, obs_ack, model_delay(lat));
                end
                tests_run++;
                if ({obs_dm_ack, obs_if_ack, obs_err} !== {own, ~own, ~dlv}) begin
                    tests_failed++; $display("FAIL random_ack[%0d]: got dm/if/err=%b want %b", t, {obs_dm_ack, obs_if_ack, obs_err}, {own, ~own, ~dlv});
                end
                tests_run++;
                if (obs_if_rdata !== if_rdata_m || obs_dm_rdata !== dm_rdata_m) begin
                    tests_failed++; $display("FAIL random_data[%0d]: got if=%h dm=%h want if=%h dm=%h", t, obs_if_rdata, obs_dm_rdata, if_rdata_m, dm_rdata_m);
                end
                tests_run++;
                if ({obs_we, obs_f3, obs_addr, obs_wdata} !== exp_cmd) begin
                    tests_failed++; $display("FAIL random_cmd[%0d]: got %h want %h", t, {obs_we, obs_f3, obs_addr, obs_wdata}, exp_cmd);
                end
                tick();
                if (own) bus.dm_req = 0; else bus.if_req = 0;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_timeout();
        test_boundary();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
